// File: rtl/bridge_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : bridge_pkg
//  Description : Shared types and constants for the ASCII receive bridge.
//                Holds the parser state encoding and the ASCII codes of the
//                command and terminator characters.
//  Revision    : 1.0 - initial release
// ============================================================================
package bridge_pkg;

    // Parser states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2,
        ST_TERM = 2'd3
    } state_t;

    // Command and terminator characters
    localparam logic [7:0] c_ascii_r  = 8'h52;  // 'R'
    localparam logic [7:0] c_ascii_w  = 8'h57;  // 'W'
    localparam logic [7:0] c_ascii_cr = 8'h0D;  // carriage return
    localparam logic [7:0] c_ascii_lf = 8'h0A;  // line feed

endpackage : bridge_pkg
`default_nettype wire

// File: rtl/bridge_rx_hex_decode.sv
`default_nettype none
// ============================================================================
//  Module      : hex_decode
//  Description : Combinational ASCII hex digit decoder. Accepts 0-9, A-F and
//                a-f; every other byte is reported as non-hex.
//  Ports       : ascii   (in,  8) byte to decode
//                nibble  (out, 4) decoded value, 0 when not hex
//                is_hex  (out, 1) byte is a valid hex digit
//  Revision    : 1.0 - initial release
// ============================================================================
module hex_decode (
    input  logic [7:0] ascii,
    output logic [3:0] nibble,
    output logic       is_hex
);

    always_comb begin
        nibble = 4'h0;
        is_hex = 1'b0;
        if (ascii >= 8'h30 && ascii <= 8'h39) begin
            nibble = ascii[3:0];
            is_hex = 1'b1;
        end else if ((ascii >= 8'h41 && ascii <= 8'h46) ||
                     (ascii >= 8'h61 && ascii <= 8'h66)) begin
            // 'A'/'a' have low nibble 1, so value = low nibble + 9
            nibble = ascii[3:0] + 4'd9;
            is_hex = 1'b1;
        end
    end

endmodule : hex_decode
`default_nettype wire

// File: rtl/bridge_rx.sv
`default_nettype none
// ============================================================================
//  Module      : bridge_rx
//  Description : Receive-side host bridge. Parses an ASCII byte stream of the
//                form R<addr>\r|\n or W<addr><data>\r|\n into single-cycle
//                transactions on the daisy-chained register bus. Malformed
//                messages are dropped and flagged with a one-cycle err_o.
//  Ports       : clk      (in)  system clock, rising edge
//                rst      (in)  asynchronous active-high reset
//                data_i   (in)  received byte
//                valid_i  (in)  data_i valid qualifier
//                addr_o   (out) bus address
//                wdata_o  (out) bus write data
//                rdata_o  (out) chain read data, tied to zero
//                rw_o     (out) 0 = read, 1 = write
//                valid_o  (out) one-cycle transaction strobe
//                err_o    (out) one-cycle abandoned-message pulse
//  Revision    : 1.0 - initial release
// ============================================================================
module bridge_rx
    import bridge_pkg::*;
#(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [7:0]            data_i,
    input  logic                  valid_i,
    output logic [ADDR_WIDTH-1:0] addr_o,
    output logic [DATA_WIDTH-1:0] wdata_o,
    output logic [DATA_WIDTH-1:0] rdata_o,
    output logic                  rw_o,
    output logic                  valid_o,
    output logic                  err_o
);

    // Index of the final digit of each field
    localparam logic [3:0] c_addr_last = 4'(ADDR_WIDTH / 4 - 1);
    localparam logic [3:0] c_data_last = 4'(DATA_WIDTH / 4 - 1);

    state_t                r_state;
    logic [3:0]            r_cnt;
    logic [ADDR_WIDTH-1:0] r_addr_acc;
    logic [DATA_WIDTH-1:0] r_data_acc;
    logic                  r_rw;

    state_t                w_state_nx;
    logic [3:0]            w_cnt_nx;
    logic [ADDR_WIDTH-1:0] w_addr_nx;
    logic [DATA_WIDTH-1:0] w_data_nx;
    logic                  w_rw_nx;
    logic                  w_issue;
    logic                  w_err;
    logic                  w_abandon;

    logic [3:0]            w_nibble;
    logic                  w_is_hex;
    logic                  w_is_cmd;
    logic                  w_is_term;

    hex_decode u_hex_decode (
        .ascii  (data_i),
        .nibble (w_nibble),
        .is_hex (w_is_hex)
    );

    assign w_is_cmd  = (data_i == c_ascii_r) || (data_i == c_ascii_w);
    assign w_is_term = (data_i == c_ascii_cr) || (data_i == c_ascii_lf);

    always_comb begin
        w_state_nx = r_state;
        w_cnt_nx   = r_cnt;
        w_addr_nx  = r_addr_acc;
        w_data_nx  = r_data_acc;
        w_rw_nx    = r_rw;
        w_issue    = 1'b0;
        w_err      = 1'b0;
        w_abandon  = 1'b0;

        if (valid_i) begin
            case (r_state)
                ST_IDLE: begin
                    // Anything other than a command byte is dropped silently,
                    // which swallows the second half of a \r\n pair.
                    if (w_is_cmd) begin
                        w_state_nx = ST_ADDR;
                        w_rw_nx    = (data_i == c_ascii_w);
                        w_cnt_nx   = 4'd0;
                        w_addr_nx  = '0;
                        w_data_nx  = '0;
                    end
                end
                ST_ADDR: begin
                    if (w_is_hex) begin
                        w_addr_nx = (r_addr_acc << 4) | ADDR_WIDTH'(w_nibble);
                        if (r_cnt == c_addr_last) begin
                            w_cnt_nx   = 4'd0;
                            w_state_nx = r_rw ? ST_DATA : ST_TERM;
                        end else begin
                            w_cnt_nx = r_cnt + 4'd1;
                        end
                    end else begin
                        w_abandon = 1'b1;
                    end
                end
                ST_DATA: begin
                    if (w_is_hex) begin
                        w_data_nx = (r_data_acc << 4) | DATA_WIDTH'(w_nibble);
                        if (r_cnt == c_data_last) begin
                            w_cnt_nx   = 4'd0;
                            w_state_nx = ST_TERM;
                        end else begin
                            w_cnt_nx = r_cnt + 4'd1;
                        end
                    end else begin
                        w_abandon = 1'b1;
                    end
                end
                ST_TERM: begin
                    if (w_is_term) begin
                        w_issue    = 1'b1;
                        w_state_nx = ST_IDLE;
                    end else begin
                        w_abandon = 1'b1;
                    end
                end
                default: begin
                    w_state_nx = ST_IDLE;
                end
            endcase

            // A command byte mid-message restarts parsing as that command;
            // any other stray byte returns to idle.
            if (w_abandon) begin
                w_err     = 1'b1;
                w_cnt_nx  = 4'd0;
                w_addr_nx = '0;
                w_data_nx = '0;
                if (w_is_cmd) begin
                    w_state_nx = ST_ADDR;
                    w_rw_nx    = (data_i == c_ascii_w);
                end else begin
                    w_state_nx = ST_IDLE;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_cnt      <= 4'd0;
            r_addr_acc <= '0;
            r_data_acc <= '0;
            r_rw       <= 1'b0;
            addr_o     <= '0;
            wdata_o    <= '0;
            rw_o       <= 1'b0;
            valid_o    <= 1'b0;
            err_o      <= 1'b0;
        end else begin
            r_state    <= w_state_nx;
            r_cnt      <= w_cnt_nx;
            r_addr_acc <= w_addr_nx;
            r_data_acc <= w_data_nx;
            r_rw       <= w_rw_nx;
            valid_o    <= w_issue;
            err_o      <= w_err;
            if (w_issue) begin
                addr_o <= r_addr_acc;
                rw_o   <= r_rw;
                // Reads leave the last written data visible on the bus
                if (r_rw) begin
                    wdata_o <= r_data_acc;
                end
            end
        end
    end

    assign rdata_o = '0;

endmodule : bridge_rx
`default_nettype wire
